// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
// Tags describe the destination-register state of one in-flight instruction.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
        logic       regWrite;
        logic       memToReg;
    } tag_t;

    localparam tag_t TAG_BUBBLE = '{default: '0};

    // The instruction now in E moves to M next cycle, so it outranks M (moving to W).
    function automatic logic [1:0] fwd_select(input logic match_in_e, input logic match_in_m);
        if (match_in_e)
            return FWD_MEM;
        else if (match_in_m)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-stage hazard inputs and pipeline control outputs of the hazard controller.
// master = CPU datapath side, slave = hazard_ctrl.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       rsD;
    logic [4:0]       rtD;
    logic             useRsD;
    logic             useRtD;
    logic [4:0]       dstD;
    logic             regWriteD;
    logic             memToRegD;
    logic             branchD;
    logic             jrD;
    logic             jumpD;
    logic             pcSrcD;
    logic             overflowE;

    logic             stallF;
    logic             stallD;
    logic             flushD;
    logic             flushE;
    logic             forwardAD;
    logic             forwardBD;
    logic [1:0]       forwardAE;
    logic [1:0]       forwardBE;
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] flushCnt;

    modport master (
        output rsD, rtD, useRsD, useRtD, dstD, regWriteD, memToRegD,
               branchD, jrD, jumpD, pcSrcD, overflowE,
        input  stallF, stallD, flushD, flushE, forwardAD, forwardBD,
               forwardAE, forwardBE, stallCnt, flushCnt
    );

    modport slave (
        input  rsD, rtD, useRsD, useRtD, dstD, regWriteD, memToRegD,
               branchD, jrD, jumpD, pcSrcD, overflowE,
        output stallF, stallD, flushD, flushE, forwardAD, forwardBD,
               forwardAE, forwardBE, stallCnt, flushCnt
    );

endinterface

// File: rtl/hazard_match.sv
// Compares one pipeline tag against one decode-stage source register.
// load_match additionally flags that the matching producer is a load.
module hazard_match
    import hazard_pkg::*;
(
    input  tag_t       tag,
    input  logic [4:0] src,
    input  logic       use_src,
    output logic       match,
    output logic       load_match
);

    // Register 0 is hard-wired, so a write to it never creates a dependency.
    assign match = tag.valid && tag.regWrite && (tag.dst != REG_ZERO)
                   && (tag.dst == src) && use_src;

    assign load_match = match && tag.memToReg;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: E/M/W tag pipeline, stall and
// flush generation, operand forwarding selects and saturating event counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input logic          clock,
    input logic          init,
    hazard_ctrl_if.slave hif
);

    localparam int STAGES = 3;
    localparam int ST_E   = 0;
    localparam int ST_M   = 1;

    tag_t             tag_pipe_reg [STAGES];
    tag_t             tag_d;
    logic [1:0][4:0]  src;
    logic [1:0]       use_flag;
    logic [1:0]       match_e;
    logic [1:0]       match_m;
    logic [1:0]       load_e;
    logic [1:0]       load_m;
    logic [1:0][1:0]  fwd_next;
    logic [1:0][1:0]  fwd_reg;
    logic             reads_rs_in_d;
    logic             load_use;
    logic             branch_haz;
    logic             stall;
    logic             flush_e;
    logic             flush_d;
    logic             redirect;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_reg;

    // Index 0 = rs (operand A), index 1 = rt (operand B).
    assign src      = {hif.rtD, hif.rsD};
    assign use_flag = {hif.useRtD, hif.useRsD};
    assign tag_d    = '{valid: 1'b1, dst: hif.dstD, regWrite: hif.regWriteD,
                        memToReg: hif.memToRegD};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            hazard_match u_match_e (
                .tag        (tag_pipe_reg[ST_E]),
                .src        (src[gi]),
                .use_src    (use_flag[gi]),
                .match      (match_e[gi]),
                .load_match (load_e[gi])
            );
            hazard_match u_match_m (
                .tag        (tag_pipe_reg[ST_M]),
                .src        (src[gi]),
                .use_src    (use_flag[gi]),
                .match      (match_m[gi]),
                .load_match (load_m[gi])
            );
            assign fwd_next[gi] = flush_e ? FWD_RF : fwd_select(match_e[gi], match_m[gi]);
        end
    endgenerate

    // Branches compare both operands in D; jr only reads rs there.
    assign reads_rs_in_d = hif.branchD | hif.jrD;
    assign load_use      = |load_e;
    assign branch_haz    = (reads_rs_in_d & (match_e[0] | load_m[0]))
                         | (hif.branchD   & (match_e[1] | load_m[1]));

    assign stall    = load_use | branch_haz;
    assign flush_e  = stall | hif.overflowE;
    assign redirect = (hif.branchD & hif.pcSrcD) | hif.jumpD | hif.jrD;
    // A stalled redirect is dropped here and re-resolved once the operands are ready.
    assign flush_d  = (redirect & ~stall) | hif.overflowE;

    always_ff @(posedge clock or posedge init) begin
        if (init) begin
            for (int i = 0; i < STAGES; i++)
                tag_pipe_reg[i] <= TAG_BUBBLE;
        end else begin
            tag_pipe_reg[ST_E] <= flush_e ? TAG_BUBBLE : tag_d;
            for (int i = 1; i < STAGES; i++)
                tag_pipe_reg[i] <= tag_pipe_reg[i-1];
        end
    end

    always_ff @(posedge clock or posedge init) begin
        if (init) begin
            fwd_reg       <= '0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            fwd_reg <= fwd_next;
            if (stall && (stall_cnt_reg != '1))
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            if (flush_d && (flush_cnt_reg != '1))
                flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
        end
    end

    assign hif.stallF    = stall;
    assign hif.stallD    = stall;
    assign hif.flushE    = flush_e;
    assign hif.flushD    = flush_d;
    // ALUOutM is only usable in D when M is not a load.
    assign hif.forwardAD = match_m[0] & ~load_m[0];
    assign hif.forwardBD = match_m[1] & ~load_m[1];
    assign hif.forwardAE = fwd_reg[0];
    assign hif.forwardBE = fwd_reg[1];
    assign hif.stallCnt  = stall_cnt_reg;
    assign hif.flushCnt  = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed, table-driven bench for hazard_ctrl plus hand-written reset and
// counter-saturation sequences (a narrow-counter instance shows saturation quickly).
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int SMALL_W = 6;
    localparam int NVEC    = 37;

    typedef struct {
        int rs, rt, ur, ut, dst, rw, mtr, br, jr, jmp, pc, ovf;
        int e_st, e_fd, e_fad, e_fbd, e_fae, e_fbe, e_sc, e_fc;
    } vec_t;

    logic clock = 1'b0;
    logic init;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs [NVEC];

    hazard_ctrl_if #(.CNT_W(16))      hif ();
    hazard_ctrl_if #(.CNT_W(SMALL_W)) sif ();

    hazard_ctrl #(.CNT_W(16))      dut     (.clock(clock), .init(init), .hif(hif));
    hazard_ctrl #(.CNT_W(SMALL_W)) dut_sat (.clock(clock), .init(init), .hif(sif));

    assign sif.rsD       = hif.rsD;
    assign sif.rtD       = hif.rtD;
    assign sif.useRsD    = hif.useRsD;
    assign sif.useRtD    = hif.useRtD;
    assign sif.dstD      = hif.dstD;
    assign sif.regWriteD = hif.regWriteD;
    assign sif.memToRegD = hif.memToRegD;
    assign sif.branchD   = hif.branchD;
    assign sif.jrD       = hif.jrD;
    assign sif.jumpD     = hif.jumpD;
    assign sif.pcSrcD    = hif.pcSrcD;
    assign sif.overflowE = hif.overflowE;

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t v(input int rs, rt, ur, ut, dst, rw, mtr, br, jr, jmp, pc, ovf,
                               input int st, fd, fad, fbd, fae, fbe, sc, fc);
        vec_t r;
        r.rs = rs; r.rt = rt; r.ur = ur; r.ut = ut; r.dst = dst; r.rw = rw; r.mtr = mtr;
        r.br = br; r.jr = jr; r.jmp = jmp; r.pc = pc; r.ovf = ovf;
        r.e_st = st; r.e_fd = fd; r.e_fad = fad; r.e_fbd = fbd;
        r.e_fae = fae; r.e_fbe = fbe; r.e_sc = sc; r.e_fc = fc;
        return r;
    endfunction

    task automatic drive(input vec_t d);
        hif.rsD       = 5'(d.rs);
        hif.rtD       = 5'(d.rt);
        hif.useRsD    = 1'(d.ur);
        hif.useRtD    = 1'(d.ut);
        hif.dstD      = 5'(d.dst);
        hif.regWriteD = 1'(d.rw);
        hif.memToRegD = 1'(d.mtr);
        hif.branchD   = 1'(d.br);
        hif.jrD       = 1'(d.jr);
        hif.jumpD     = 1'(d.jmp);
        hif.pcSrcD    = 1'(d.pc);
        hif.overflowE = 1'(d.ovf);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    initial begin
        vec_t nop;
        nop = v(0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0);

        //            rs rt ur ut dst rw mtr br jr j pc ov | st fd fad fbd fae fbe sc fc
        // addi gr1; addi gr2; add gr4=gr1+gr2
        vecs[0]  = v( 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = v( 0, 0, 1, 0, 2, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        vecs[2]  = v( 1, 2, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0, 0);
        vecs[3]  = v( 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 2, 0, 0);
        // lw gr5; add gr6=gr2+gr5 (one load-use stall)
        vecs[4]  = v( 0, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        vecs[5]  = v( 2, 5, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);
        vecs[6]  = v( 2, 5, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0);
        vecs[7]  = v( 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 1, 0);
        // addi gr5=1; addi gr5=2; addi gr6=gr5+0 (youngest writer wins)
        vecs[8]  = v( 0, 0, 1, 0, 5, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0);
        vecs[9]  = v( 0, 0, 1, 0, 5, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0);
        vecs[10] = v( 5, 0, 1, 0, 6, 1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 1, 0);
        vecs[11] = v( 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2, 0, 1, 0);
        // lw gr1; beq gr1,gr1 taken (two stalls, then flushD)
        vecs[12] = v( 0, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0);
        vecs[13] = v( 1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 1, 0);
        vecs[14] = v( 1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 2, 0);
        vecs[15] = v( 1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 1, 0,  0, 1, 0, 0, 0, 0, 3, 0);
        vecs[16] = v( 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 3, 1);
        // j; add; gr0 writers and readers never interact
        vecs[17] = v( 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 1, 0, 0, 0, 0, 3, 1);
        vecs[18] = v( 1, 2, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 3, 2);
        vecs[19] = v( 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 3, 2);
        vecs[20] = v( 0, 0, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 3, 2);
        vecs[21] = v( 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 3, 2);
        vecs[22] = v( 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 3, 2);
        vecs[23] = v( 0, 0, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 3, 2);
        vecs[24] = v( 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 3, 2);
        // overflow in E
        vecs[25] = v( 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0, 0, 3, 2);
        // addi gr3; nop; beq gr0,gr3 not taken (forwardBD from ALUOutM)
        vecs[26] = v( 0, 0, 1, 0, 3, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 3, 3);
        vecs[27] = v( 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 3, 3);
        vecs[28] = v( 0, 3, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 3, 3);
        // addi gr3; bne gr3,gr0 taken (ALU-producer branch stall suppresses flushD)
        vecs[29] = v( 0, 0, 1, 0, 3, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 3, 3);
        vecs[30] = v( 3, 0, 1, 1, 0, 0, 0, 1, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 3, 3);
        vecs[31] = v( 3, 0, 1, 1, 0, 0, 0, 1, 0, 0, 1, 0,  0, 1, 1, 0, 0, 0, 4, 3);
        vecs[32] = v( 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 4, 4);
        // addi gr31; jr gr31
        vecs[33] = v( 0, 0, 1, 0,31, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 4, 4);
        vecs[34] = v(31, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 4, 4);
        vecs[35] = v(31, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 1, 0, 0, 0, 5, 4);
        vecs[36] = v( 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 5, 5);

        // Reset state
        init = 1'b1;
        drive(nop);
        repeat (2) @(posedge clock);
        @(negedge clock);
        init = 1'b0;
        chk("reset_stallF",   int'(hif.stallF), 0);
        chk("reset_flushE",   int'(hif.flushE), 0);
        chk("reset_flushD",   int'(hif.flushD), 0);
        chk("reset_fwdAE",    int'(hif.forwardAE), 0);
        chk("reset_fwdBE",    int'(hif.forwardBE), 0);
        chk("reset_stallCnt", int'(hif.stallCnt), 0);
        chk("reset_flushCnt", int'(hif.flushCnt), 0);
        $display("reset stallF=%0b flushD=%0b fwdAE=%02b stallCnt=%0d", hif.stallF, hif.flushD,
                 hif.forwardAE, hif.stallCnt);

        for (int i = 0; i < NVEC; i++) begin
            @(posedge clock);
            #1;
            drive(vecs[i]);
            @(negedge clock);
            $display("vec %0d stall=%0b flushD=%0b flushE=%0b fAD=%0b fBD=%0b fAE=%02b fBE=%02b sCnt=%0d fCnt=%0d",
                     i, hif.stallF, hif.flushD, hif.flushE, hif.forwardAD, hif.forwardBD,
                     hif.forwardAE, hif.forwardBE, hif.stallCnt, hif.flushCnt);
            chk($sformatf("v%0d_stallF", i),   int'(hif.stallF),    vecs[i].e_st);
            chk($sformatf("v%0d_stallD", i),   int'(hif.stallD),    vecs[i].e_st);
            chk($sformatf("v%0d_flushE", i),   int'(hif.flushE),    vecs[i].e_st | vecs[i].ovf);
            chk($sformatf("v%0d_flushD", i),   int'(hif.flushD),    vecs[i].e_fd);
            chk($sformatf("v%0d_fwdAD", i),    int'(hif.forwardAD), vecs[i].e_fad);
            chk($sformatf("v%0d_fwdBD", i),    int'(hif.forwardBD), vecs[i].e_fbd);
            chk($sformatf("v%0d_fwdAE", i),    int'(hif.forwardAE), vecs[i].e_fae);
            chk($sformatf("v%0d_fwdBE", i),    int'(hif.forwardBE), vecs[i].e_fbe);
            chk($sformatf("v%0d_stallCnt", i), int'(hif.stallCnt),  vecs[i].e_sc);
            chk($sformatf("v%0d_flushCnt", i), int'(hif.flushCnt),  vecs[i].e_fc);
        end

        // Reset mid-stall: addi gr5; lw gr6<-(gr5); add gr7 uses gr6
        @(posedge clock); #1;
        drive(v(0,0,1,0,5,1,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
        @(posedge clock); #1;
        drive(v(5,0,1,0,6,1,1,0,0,0,0,0, 0,0,0,0,0,0,0,0));
        @(posedge clock); #1;
        drive(v(6,0,1,0,7,1,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
        @(negedge clock);
        chk("pre_rst_stall",    int'(hif.stallF), 1);
        chk("pre_rst_fwdAE",    int'(hif.forwardAE), 2);
        chk("pre_rst_stallCnt", int'(hif.stallCnt), 5);
        $display("pre-reset stall=%0b fwdAE=%02b stallCnt=%0d", hif.stallF, hif.forwardAE, hif.stallCnt);
        #1 init = 1'b1;
        #1;
        chk("rst_mid_stallF",   int'(hif.stallF), 0);
        chk("rst_mid_stallD",   int'(hif.stallD), 0);
        chk("rst_mid_flushE",   int'(hif.flushE), 0);
        chk("rst_mid_flushD",   int'(hif.flushD), 0);
        chk("rst_mid_fwdAE",    int'(hif.forwardAE), 0);
        chk("rst_mid_stallCnt", int'(hif.stallCnt), 0);
        chk("rst_mid_flushCnt", int'(hif.flushCnt), 0);
        $display("mid-stall reset stall=%0b fwdAE=%02b stallCnt=%0d", hif.stallF, hif.forwardAE, hif.stallCnt);
        #1 init = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("post_rst_stall",    int'(hif.stallF), 0);
        chk("post_rst_fwdAE",    int'(hif.forwardAE), 0);
        chk("post_rst_stallCnt", int'(hif.stallCnt), 0);
        $display("post-reset stall=%0b fwdAE=%02b stallCnt=%0d", hif.stallF, hif.forwardAE, hif.stallCnt);

        // Repeating load-fed branch: stalls two cycles of every three
        @(posedge clock); #1;
        init = 1'b1;
        drive(v(5,0,1,0,5,1,1,1,0,0,0,0, 0,0,0,0,0,0,0,0));
        #2 init = 1'b0;
        repeat (150) @(posedge clock);
        @(negedge clock);
        chk("sat_stallCnt_wide",  int'(hif.stallCnt), 100);
        chk("sat_stallCnt_small", int'(sif.stallCnt), (1 << SMALL_W) - 1);
        chk("sat_flushCnt_wide",  int'(hif.flushCnt), 0);
        $display("stall run wide=%0d small=%0d", hif.stallCnt, sif.stallCnt);

        @(posedge clock); #1;
        drive(v(0,0,0,0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0,0));
        repeat (70) @(posedge clock);
        @(negedge clock);
        chk("sat_ovf_flushD",      int'(hif.flushD), 1);
        chk("sat_flushCnt_wide",   int'(hif.flushCnt), 70);
        chk("sat_flushCnt_small",  int'(sif.flushCnt), (1 << SMALL_W) - 1);
        chk("sat_stallHold_wide",  int'(hif.stallCnt), 100);
        chk("sat_stallHold_small", int'(sif.stallCnt), (1 << SMALL_W) - 1);
        $display("flush run wide=%0d small=%0d", hif.flushCnt, sif.flushCnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
